// File: rtl/fin_meas.sv
// Reference-period meter: counts dco_clk cycles between fin rising edges, with glitch
// rejection and loss-of-reference flag. Define FIN_MEAS_AVG_EN for a 4-period averager.
module fin_meas #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_P       = 4
) (
  input  logic             dco_clk,
  input  logic             rst_n,
  input  logic             fin,
  output logic [CNT_W-1:0] fin_w,
  output logic             fin_vld,
  output logic             fin_ovf
);

  typedef enum logic [1:0] {IDLE, COUNT, LOST} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_P);

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   edge_det;
  logic                   meas;
  logic                   lost;

  always_ff @(posedge dco_clk) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], fin};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync[SYNC_STAGES-1] & ~hist;

  always_ff @(posedge dco_clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Edge wins over overflow, so a period of exactly CNT_MAX is still a measurement.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    meas    = 1'b0;
    lost    = 1'b0;
    case (state)
      IDLE, LOST: begin
        if (edge_det) begin
          cnt_n   = CNT_W'(1);
          state_n = COUNT;
        end
      end
      COUNT: begin
        if (edge_det && cnt >= MIN_C) begin
          meas  = 1'b1;
          cnt_n = CNT_W'(1);
        end else if (cnt == CNT_MAX) begin
          lost    = 1'b1;
          state_n = LOST;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef FIN_MEAS_AVG_EN
  logic [CNT_W+1:0] sum;
  logic [CNT_W+1:0] sum_n;
  logic [1:0]       phase;

  assign sum_n = sum + {2'b00, cnt};

  always_ff @(posedge dco_clk) begin
    if (!rst_n) begin
      fin_w   <= '0;
      fin_vld <= 1'b0;
      fin_ovf <= 1'b0;
      sum     <= '0;
      phase   <= '0;
    end else begin
      fin_vld <= 1'b0;
      if (meas) begin
        if (phase == 2'd3) begin
          fin_w   <= sum_n[CNT_W+1:2];
          fin_vld <= 1'b1;
          fin_ovf <= 1'b0;
          sum     <= '0;
          phase   <= '0;
        end else begin
          sum   <= sum_n;
          phase <= phase + 2'd1;
        end
      end else if (lost || state == IDLE) begin
        if (lost) begin
          fin_w   <= CNT_MAX;
          fin_ovf <= 1'b1;
        end
        sum   <= '0;
        phase <= '0;
      end
    end
  end
`else
  always_ff @(posedge dco_clk) begin
    if (!rst_n) begin
      fin_w   <= '0;
      fin_vld <= 1'b0;
      fin_ovf <= 1'b0;
    end else begin
      fin_vld <= 1'b0;
      if (meas) begin
        fin_w   <= cnt;
        fin_vld <= 1'b1;
        fin_ovf <= 1'b0;
      end else if (lost) begin
        fin_w   <= CNT_MAX;
        fin_ovf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fin_meas.sv
// Randomized/directed bench for fin_meas against an edge-time based period model.
module tb_fin_meas;

  localparam int  MIN_P   = 4;
  localparam longint MAXC = 65535;

  logic        dco_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        fin     = 1'b0;
  logic [15:0] fin_w;
  logic        fin_vld;
  logic        fin_ovf;

  int     tests = 0;
  int     fails = 0;
  longint cyc   = 0;

  // reference model state
  bit     armed   = 1'b0;
  longint last    = 0;
  longint exp_w   = 0;
  bit     exp_ovf = 1'b0;
  longint acc[$];
  longint exp_q[$];
  longint got_q[$];

  fin_meas #(.CNT_W(16), .SYNC_STAGES(2), .MIN_P(MIN_P)) dut (
    .dco_clk (dco_clk),
    .rst_n   (rst_n),
    .fin     (fin),
    .fin_w   (fin_w),
    .fin_vld (fin_vld),
    .fin_ovf (fin_ovf)
  );

  always #5 dco_clk = ~dco_clk;
  always @(posedge dco_clk) cyc <= cyc + 1;
  always @(negedge dco_clk) if (rst_n && fin_vld) got_q.push_back(longint'(fin_w));

  task automatic chk(input string tag, input longint obs, input longint expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void emit(input longint v);
    exp_q.push_back(v);
    exp_w   = v;
    exp_ovf = 1'b0;
  endfunction

  function automatic void go_lost();
    armed   = 1'b0;
    exp_w   = MAXC;
    exp_ovf = 1'b1;
    acc.delete();
  endfunction

  function automatic void model_reset();
    armed = 1'b0; exp_w = 0; exp_ovf = 1'b0;
    acc.delete(); exp_q.delete(); got_q.delete();
  endfunction

  function automatic void model_rise(input longint t);
    longint p, s;
    if (armed && t - last > MAXC) go_lost();
    if (!armed) begin
      armed = 1'b1;
      last  = t;
      acc.delete();
    end else if (t - last >= MIN_P) begin
      p    = t - last;
      last = t;
`ifdef FIN_MEAS_AVG_EN
      acc.push_back(p);
      if (acc.size() == 4) begin
        s = 0;
        foreach (acc[i]) s += acc[i];
        emit(s / 4);
        acc.delete();
      end
`else
      s = p;
      emit(s);
`endif
    end
  endfunction

  // Rising edge now, high for 'high' cycles, then low for 'low' cycles.
  task automatic rise(input int high, input int low);
    fin = 1'b1;
    model_rise(cyc);
    repeat (high) @(negedge dco_clk);
    fin = 1'b0;
    repeat (low) @(negedge dco_clk);
  endtask

  task automatic periods(input int p, input int n);
    for (int i = 0; i < n; i++) rise(2, p - 2);
  endtask

  task automatic check_results(input string tag);
    int n;
    if (armed && cyc - last > MAXC + 8) go_lost();
    chk({tag, " count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, " fin_w pulse"}, got_q[i], exp_q[i]);
    chk({tag, " fin_w level"}, longint'(fin_w), exp_w);
    chk({tag, " fin_ovf"}, longint'(fin_ovf), longint'(exp_ovf));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic settle(input string tag);
    fin = 1'b0;
    repeat (10) @(negedge dco_clk);
    check_results(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(negedge dco_clk);
    chk({tag, " fin_w"}, longint'(fin_w), 0);
    chk({tag, " fin_vld"}, longint'(fin_vld), 0);
    chk({tag, " fin_ovf"}, longint'(fin_ovf), 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int p, h;
    repeat (3) @(negedge dco_clk);
    do_reset("reset");
    repeat (3) @(negedge dco_clk);

    // basic period then switch 100 -> 37 without a gap
    periods(100, 6);
    periods(37, 5);
    settle("basic_change");

    // glitch 2 cycles after an edge
    periods(100, 3);
    rise(1, 1);
    rise(2, 96);
    periods(100, 2);
    settle("glitch");

    // MIN_P boundary: gap 4 accepted, gap 3 ignored
    periods(4, 3);
    rise(1, 2);
    periods(4, 2);
    settle("min_p");

    // random periods
    for (int i = 0; i < 24; i++) begin
      p = $urandom_range(150, MIN_P);
      h = $urandom_range(p - 2, 2);
      rise(h, p - h);
    end
    settle("random");

    // loss of reference, then restart at 50
    periods(100, 2);
    repeat (65545) @(negedge dco_clk);
    check_results("loss");
    periods(50, 6);
    settle("restart");

    // reset mid-count at cnt ~ 60
    periods(100, 2);
    rise(2, 58);
    check_results("pre_reset");
    do_reset("mid_reset");
    repeat (40) @(negedge dco_clk);
    periods(100, 3);
    settle("post_reset");

    // averaging pattern 100..103 then 4x10
    do_reset("avg_reset");
    repeat (3) @(negedge dco_clk);
    rise(2, 98);
    rise(2, 99);
    rise(2, 100);
    rise(2, 101);
    periods(10, 5);
    settle("avg_pattern");
    chk("final fin_w", longint'(fin_w), 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
